// File: rtl/ram_arbiter_pkg.sv
// Shared widths and FSM state encodings for the two-requester RAM arbiter.
// Optional feature macro: RAM_ARB_INIT_CLEAR_EN (clear-memory sequence after reset).
package ram_arbiter_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 4;
   localparam int DEPTH      = 2 ** ADDR_WIDTH;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester/RAM bundle for ram_arbiter. The slave modport is the arbiter side;
// the master modport is the requesters plus the RAM data return.
// Optional feature macro: RAM_ARB_INIT_CLEAR_EN (drives busy).
interface ram_arbiter_if
   import ram_arbiter_pkg::*;
#(
   parameter int DATA_W = DATA_WIDTH,
   parameter int ADDR_W = ADDR_WIDTH
);
   logic              req0, req1;
   logic              we0, we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              ack0, ack1;
   logic              rvalid0, rvalid1;
   logic [DATA_W-1:0] rdata;
   logic              busy;
   logic              ram_en;
   logic              ram_wr_rd;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
      output ack0, ack1, rvalid0, rvalid1, rdata, busy,
             ram_en, ram_wr_rd, ram_addr, ram_wdata
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
      input  ack0, ack1, rvalid0, rvalid1, rdata, busy,
             ram_en, ram_wr_rd, ram_addr, ram_wdata
   );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin grant with a last_grant register. On a tie the
// requester that did not win last time is granted; any grant updates
// last_grant. Reset leaves last_grant = 1 so requester 0 wins the first tie.
module rr_arb2 (
   input  logic       clk,
   input  logic       rstn,
   input  logic [1:0] i_req,
   output logic [1:0] o_grant
);

   logic r_last_grant;

   // One-hot grant from the current requests and the last winner
   always_comb begin
      o_grant = 2'b00;
      case (i_req)
         2'b01:   o_grant = 2'b01;
         2'b10:   o_grant = 2'b10;
         2'b11:   o_grant = r_last_grant ? 2'b01 : 2'b10;
         default: o_grant = 2'b00;
      endcase
   end

   // Remember who won so the next tie goes the other way
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         r_last_grant <= 1'b1;
      else if (o_grant[0])
         r_last_grant <= 1'b0;
      else if (o_grant[1])
         r_last_grant <= 1'b1;
   end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of a single-port RAM
// with one-cycle read latency. All RAM command outputs, acks and rvalids are
// registered; rdata is the RAM output passed straight through.
// Optional feature macro: RAM_ARB_INIT_CLEAR_EN -- after reset, write 0 to
// every address (busy high) before accepting requests.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int DATA_W = DATA_WIDTH,
   parameter int ADDR_W = ADDR_WIDTH,
   parameter int NREQ   = 2
)(
   input  logic          clk,
   input  logic          rstn,
   ram_arbiter_if.slave  bus
);

   logic              r_ack0, r_ack1;
   logic              r_rvalid0, r_rvalid1;
   logic              r_ram_en, r_ram_wr_rd;
   logic [ADDR_W-1:0] r_ram_addr;
   logic [DATA_W-1:0] r_ram_wdata;
   logic              r_rd_pend, r_rd_owner;

   logic              w_idle;
   logic [NREQ-1:0]   w_req, w_grant;
   logic              w_cmd_en, w_cmd_wr;
   logic [ADDR_W-1:0] w_cmd_addr;
   logic [DATA_W-1:0] w_cmd_wdata;
   logic              w_ack0, w_ack1, w_rd_pend, w_rd_owner;

`ifdef RAM_ARB_INIT_CLEAR_EN
   state_t            r_state;
   logic [ADDR_W:0]   r_init_cnt;
   logic [ADDR_W:0]   w_init_cnt_next;

   assign w_init_cnt_next = r_init_cnt + {{ADDR_W{1'b0}}, 1'b1};
   assign w_idle          = (r_state == ST_IDLE);
   assign bus.busy        = (r_state == ST_INIT);

   // Clear sequence: one write per cycle; the extra counter bit flags the end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= ST_INIT;
         r_init_cnt <= '0;
      end else if (r_state == ST_INIT) begin
         r_init_cnt <= w_init_cnt_next;
         if (w_init_cnt_next[ADDR_W])
            r_state <= ST_IDLE;
      end
   end
`else
   assign w_idle   = 1'b1;
   assign bus.busy = 1'b0;
`endif

   // A requester whose ack is high this cycle is not eligible again yet
   assign w_req = {bus.req1 & ~r_ack1, bus.req0 & ~r_ack0} & {NREQ{w_idle}};

   rr_arb2 u_rr_arb2 (
      .clk     (clk),
      .rstn    (rstn),
      .i_req   (w_req),
      .o_grant (w_grant)
   );

   // Next command: granted request, INIT clear write, or idle (hold wr/addr/data)
   always_comb begin
      w_cmd_en    = 1'b0;
      w_cmd_wr    = r_ram_wr_rd;
      w_cmd_addr  = r_ram_addr;
      w_cmd_wdata = r_ram_wdata;
      w_ack0      = 1'b0;
      w_ack1      = 1'b0;
      w_rd_pend   = 1'b0;
      w_rd_owner  = r_rd_owner;
      if (w_grant[0]) begin
         w_cmd_en    = 1'b1;
         w_cmd_wr    = bus.we0;
         w_cmd_addr  = bus.addr0;
         w_cmd_wdata = bus.wdata0;
         w_ack0      = 1'b1;
         w_rd_pend   = ~bus.we0;
         w_rd_owner  = 1'b0;
      end else if (w_grant[1]) begin
         w_cmd_en    = 1'b1;
         w_cmd_wr    = bus.we1;
         w_cmd_addr  = bus.addr1;
         w_cmd_wdata = bus.wdata1;
         w_ack1      = 1'b1;
         w_rd_pend   = ~bus.we1;
         w_rd_owner  = 1'b1;
      end
`ifdef RAM_ARB_INIT_CLEAR_EN
      if (r_state == ST_INIT) begin
         w_cmd_en    = 1'b1;
         w_cmd_wr    = 1'b1;
         w_cmd_addr  = r_init_cnt[ADDR_W-1:0];
         w_cmd_wdata = '0;
      end
`endif
   end

   // Command register plus read-return tracking one stage behind it
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_ram_en    <= 1'b0;
         r_ram_wr_rd <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_ack0      <= 1'b0;
         r_ack1      <= 1'b0;
         r_rd_pend   <= 1'b0;
         r_rd_owner  <= 1'b0;
         r_rvalid0   <= 1'b0;
         r_rvalid1   <= 1'b0;
      end else begin
         r_ram_en    <= w_cmd_en;
         r_ram_wr_rd <= w_cmd_wr;
         r_ram_addr  <= w_cmd_addr;
         r_ram_wdata <= w_cmd_wdata;
         r_ack0      <= w_ack0;
         r_ack1      <= w_ack1;
         r_rd_pend   <= w_rd_pend;
         r_rd_owner  <= w_rd_owner;
         r_rvalid0   <= r_rd_pend & ~r_rd_owner;
         r_rvalid1   <= r_rd_pend &  r_rd_owner;
      end
   end

   assign bus.ram_en    = r_ram_en;
   assign bus.ram_wr_rd = r_ram_wr_rd;
   assign bus.ram_addr  = r_ram_addr;
   assign bus.ram_wdata = r_ram_wdata;
   assign bus.ack0      = r_ack0;
   assign bus.ack1      = r_ack1;
   assign bus.rvalid0   = r_rvalid0;
   assign bus.rvalid1   = r_rvalid1;
   assign bus.rdata     = bus.ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a one-cycle-latency RAM model.
// Optional feature macro: RAM_ARB_INIT_CLEAR_EN (adds the clear-sequence test).
module tb_ram_arbiter;
   import ram_arbiter_pkg::*;

   localparam int DW = DATA_WIDTH;
   localparam int AW = ADDR_WIDTH;
`ifdef RAM_ARB_INIT_CLEAR_EN
   localparam logic BUSY_RST = 1'b1;
`else
   localparam logic BUSY_RST = 1'b0;
`endif

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   busy_cnt;

   always #5 clk = ~clk;

   ram_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NREQ(2)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   // Single-port RAM model, pre-filled with FF so a clear is observable
   logic [DW-1:0] mem [2**AW] = '{default: 8'hFF};
   always @(posedge clk) begin
      if (bus.ram_en) begin
         if (bus.ram_wr_rd)
            mem[bus.ram_addr] <= bus.ram_wdata;
         else
            bus.ram_rdata <= mem[bus.ram_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int idx, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      $display("[%0t] req%0d we=%0d addr=%0h wdata=%0h", $time, idx, we, a, d);
      if (idx == 0) begin
         bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
      end else begin
         bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
      end
   endtask

   task automatic release_req(input int idx);
      if (idx == 0) bus.req0 = 1'b0;
      else          bus.req1 = 1'b0;
   endtask

   task automatic chk_rst_outs(input string tag);
      chk({tag, "_ack0"},   bus.ack0,      0);
      chk({tag, "_ack1"},   bus.ack1,      0);
      chk({tag, "_rv0"},    bus.rvalid0,   0);
      chk({tag, "_rv1"},    bus.rvalid1,   0);
      chk({tag, "_en"},     bus.ram_en,    0);
      chk({tag, "_wr"},     bus.ram_wr_rd, 0);
      chk({tag, "_addr"},   bus.ram_addr,  0);
      chk({tag, "_wdata"},  bus.ram_wdata, 0);
      chk({tag, "_busy"},   bus.busy,      BUSY_RST);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
      bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
      rstn = 1'b0;
      tick();
      tick();
      chk_rst_outs("reset");

`ifdef RAM_ARB_INIT_CLEAR_EN
      // req0 reads the top address from reset; must wait out the clear
      rstn = 1'b1;
      drive(0, 1'b0, 4'hF, 8'h00);
      busy_cnt = 0;
      for (int i = 0; i < 40 && bus.busy; i++) begin
         chk("init_noack0", bus.ack0, 0);
         busy_cnt++;
         tick();
      end
      chk("init_busy_cycles", busy_cnt, 2**AW);
      chk("init_noack_fall", bus.ack0, 0);
      tick();
      chk("init_ack0", bus.ack0, 1);
      chk("init_rd_addr", bus.ram_addr, 4'hF);
      chk("init_rd_wr", bus.ram_wr_rd, 0);
      release_req(0);
      tick();
      chk("init_rv0", bus.rvalid0, 1);
      chk("init_rdata", bus.rdata, 8'h00);
      tick();
`else
      chk("busy_off", bus.busy, 0);
      rstn = 1'b1;
      tick();
`endif

      // Write then read back through requester 0
      drive(0, 1'b1, 4'h5, 8'hA5);
      tick();
      chk("wr_ack0", bus.ack0, 1);
      chk("wr_ack1", bus.ack1, 0);
      chk("wr_en", bus.ram_en, 1);
      chk("wr_wr", bus.ram_wr_rd, 1);
      chk("wr_addr", bus.ram_addr, 5);
      chk("wr_wdata", bus.ram_wdata, 8'hA5);
      release_req(0);
      tick();
      chk("gap_ack0", bus.ack0, 0);
      chk("gap_en", bus.ram_en, 0);
      chk("hold_wr", bus.ram_wr_rd, 1);
      chk("hold_addr", bus.ram_addr, 5);
      drive(0, 1'b0, 4'h5, 8'h00);
      tick();
      chk("rd_ack0", bus.ack0, 1);
      chk("rd_wr", bus.ram_wr_rd, 0);
      chk("rd_addr", bus.ram_addr, 5);
      chk("rd_rv0_early", bus.rvalid0, 0);
      release_req(0);
      tick();
      chk("rd_rv0", bus.rvalid0, 1);
      chk("rd_rv1", bus.rvalid1, 0);
      chk("rd_rdata", bus.rdata, 8'hA5);

      // Requester 1 reads the same word; leaves last_grant = 1
      drive(1, 1'b0, 4'h5, 8'h00);
      tick();
      chk("rd1_ack1", bus.ack1, 1);
      chk("rd1_ack0", bus.ack0, 0);
      release_req(1);
      tick();
      chk("rd1_rv1", bus.rvalid1, 1);
      chk("rd1_rv0", bus.rvalid0, 0);
      chk("rd1_rdata", bus.rdata, 8'hA5);

      // Both held: grants alternate 0,1,0,1 with ram_en continuously high
      drive(0, 1'b1, 4'h1, 8'h11);
      drive(1, 1'b1, 4'h2, 8'h22);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("rr_ack0", bus.ack0, (k % 2 == 0) ? 1 : 0);
         chk("rr_ack1", bus.ack1, (k % 2 == 1) ? 1 : 0);
         chk("rr_en", bus.ram_en, 1);
         chk("rr_addr", bus.ram_addr, (k % 2 == 0) ? 1 : 2);
      end
      release_req(0);
      release_req(1);
      tick();
      chk("rr_end_en", bus.ram_en, 0);
      chk("rr_end_ack0", bus.ack0, 0);
      chk("rr_end_ack1", bus.ack1, 0);

      // Read-after-write across requesters
      drive(1, 1'b1, 4'h3, 8'h3C);
      tick();
      chk("raw_ack1", bus.ack1, 1);
      chk("raw_waddr", bus.ram_addr, 3);
      release_req(1);
      drive(0, 1'b0, 4'h3, 8'h00);
      tick();
      chk("raw_ack0", bus.ack0, 1);
      chk("raw_rd_wr", bus.ram_wr_rd, 0);
      chk("raw_rv1_a", bus.rvalid1, 0);
      release_req(0);
      tick();
      chk("raw_rv0", bus.rvalid0, 1);
      chk("raw_rdata", bus.rdata, 8'h3C);
      chk("raw_rv1_b", bus.rvalid1, 0);
      tick();
      chk("raw_rv0_off", bus.rvalid0, 0);
      chk("raw_rv1_c", bus.rvalid1, 0);

      // Idle: nothing moves
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("idle_en", bus.ram_en, 0);
         chk("idle_ack0", bus.ack0, 0);
         chk("idle_ack1", bus.ack1, 0);
         chk("idle_rv0", bus.rvalid0, 0);
         chk("idle_rv1", bus.rvalid1, 0);
      end

      // Reset right after a read ack drops the pending rvalid
      drive(0, 1'b0, 4'h3, 8'h00);
      tick();
      chk("mr_ack0", bus.ack0, 1);
      release_req(0);
      rstn = 1'b0;
      $display("[%0t] reset asserted after read ack", $time);
      #1;
      chk_rst_outs("mrst_a");
      tick();
      chk_rst_outs("mrst_b");
      rstn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("mr_rv0", bus.rvalid0, 0);
         chk("mr_ack0_after", bus.ack0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
